// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcode encodings, the ID/EX bubble value and
// the interlock state/action types used by decode, stall detect and ID/EX.
package cpu_pkg;

  localparam logic [7:0] OP_NOP = 8'd0;
  localparam logic [7:0] OP_LW  = 8'd1;
  localparam logic [7:0] OP_SW  = 8'd2;
  localparam logic [7:0] OP_ADD = 8'd3;
  localparam logic [7:0] OP_SUB = 8'd4;

  // A bubble is a NOP that writes nothing, so the stall detector sees no hazard.
  localparam logic [7:0] BUBBLE_OPCODE = OP_NOP;
  localparam logic [3:0] BUBBLE_WS     = 4'd0;
  localparam logic       BUBBLE_WE     = 1'b0;

  typedef enum logic {
    RUN     = 1'b0,
    STALLED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_FLUSH   = 2'd2
  } action_t;

  // Control fields of the ID/EX register; the immediate is carried separately
  // because its width is a module parameter.
  typedef struct packed {
    logic [7:0] opcode;
    logic [3:0] ws;
    logic       we;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '{opcode: BUBBLE_OPCODE, ws: BUBBLE_WS, we: BUBBLE_WE};

  function automatic action_t pick_action(input logic stall, input logic flush);
    if (flush)      return ACT_FLUSH;
    else if (stall) return ACT_STALL;
    else            return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_interlock.sv
// ID/EX pipeline register with load-use stall response: injects bubbles,
// gates fetch, and tracks stall cycles with a perf counter and sticky watchdog.
module id_ex_interlock
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_STALL  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [7:0]            i_decoder_opcode,
  input  logic [3:0]            i_decoder_ws,
  input  logic                  i_decoder_we,
  input  logic [DATA_WIDTH-1:0] i_decoder_imm,
  output logic [7:0]            o_execute_opcode,
  output logic [3:0]            o_execute_ws,
  output logic                  o_execute_we,
  output logic [DATA_WIDTH-1:0] o_execute_imm,
  output logic                  o_fetch_enable,
  output logic                  o_bubble,
  output logic [CNT_WIDTH-1:0]  o_stall_count,
  output logic                  o_stall_timeout
);

  localparam int              RUN_W   = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  action_t               action;
  state_t                state_q, state_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  timeout_q, timeout_d;
  logic                  bubble_q, bubble_d;
  logic                  load_bubble;
  logic                  stall_inc;
  ctrl_t                 ctrl_q;
  logic [DATA_WIDTH-1:0] imm_q;

  assign action = pick_action(i_stall, i_flush);

  // Flush wins over stall, so a killed instruction never holds fetch.
  assign o_fetch_enable = ~i_stall | i_flush;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = RUN;
    run_d       = '0;
    bubble_d    = 1'b0;
    load_bubble = 1'b0;
    stall_inc   = 1'b0;
    unique case (action)
      ACT_FLUSH: begin
        load_bubble = 1'b1;
        bubble_d    = 1'b1;
      end
      ACT_STALL: begin
        load_bubble = 1'b1;
        bubble_d    = 1'b1;
        stall_inc   = 1'b1;
        state_d     = STALLED;
        // A run starts at one on entry; once at the watchdog limit it holds there.
        if (state_q == STALLED) begin
          run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
        end else begin
          run_d = RUN_ONE;
        end
      end
      default: ;
    endcase
    timeout_d = timeout_q | (run_d == RUN_MAX);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= RUN;
      run_q     <= '0;
      timeout_q <= 1'b0;
      bubble_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
      bubble_q  <= bubble_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q <= BUBBLE_CTRL;
      imm_q  <= '0;
    end else if (load_bubble) begin
      ctrl_q <= BUBBLE_CTRL;
      imm_q  <= '0;
    end else begin
      ctrl_q <= '{opcode: i_decoder_opcode, ws: i_decoder_ws, we: i_decoder_we};
      imm_q  <= i_decoder_imm;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_counter (
    .clk  (i_clk),
    .rst  (i_reset),
    .inc  (stall_inc),
    .count(o_stall_count)
  );

  assign o_execute_opcode = ctrl_q.opcode;
  assign o_execute_ws     = ctrl_q.ws;
  assign o_execute_we     = ctrl_q.we;
  assign o_execute_imm    = imm_q;
  assign o_bubble         = bubble_q;
  assign o_stall_timeout  = timeout_q;

endmodule
